// File: rtl/counter_sequencer.sv
// counter_sequencer: run controller for a WIDTH-bit counter datapath.
// It accepts start/stop commands and walks the counter through clear, count
// and terminal-count phases by driving the counter's enable and clear inputs.
// It supports one-shot runs and periodic runs.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   start    run request (sampled only in IDLE)
//   stop     abort request (honoured in CLEAR and RUN)
//   mode     0 = one-shot, 1 = periodic (latched on an accepted start)
//   limit    terminal count (latched on an accepted start)
//   cnt_q    current counter value
//   cnt_en   counter increment enable
//   cnt_clr  counter synchronous clear (takes priority over cnt_en)
//   busy     state is not IDLE (registered)
//   tick     terminal-count pulse
//   done     end-of-run pulse (normal end or abort)
//   err      start rejected because limit == 0
//   laps     saturating count of ticks since the last accepted start (registered)
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int LAPW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic             err,
  output logic [LAPW-1:0]  laps
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

  localparam logic [LAPW-1:0] LAPS_MAX = {LAPW{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;   // latched terminal count (limit_r)
  logic             mode_q,  mode_d;    // latched run mode (mode_r)
  logic [LAPW-1:0]  laps_q,  laps_d;
  logic             hit;

  assign hit  = (cnt_q == limit_q);
  assign busy = (state_q != IDLE);
  assign laps = laps_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      limit_q <= '0;
      mode_q  <= 1'b0;
      laps_q  <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      laps_q  <= laps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    laps_d  = laps_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    tick    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    if (reset) begin
      // Keep the counter parked at zero while the block is reset. A run that
      // is cut off by reset ends silently, without a done pulse.
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // If start and stop arrive together, both are ignored.
          if (start && !stop) begin
            if (limit == '0) begin
              err = 1'b1;
            end else begin
              limit_d = limit;
              mode_d  = mode;
              laps_d  = '0;
              state_d = CLEAR;
            end
          end
        end
        CLEAR: begin
          cnt_clr = 1'b1;
          if (stop) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
        end
        RUN: begin
          // stop wins over a coincident hit: no tick, and laps is untouched.
          if (stop) begin
            cnt_clr = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
          end else if (hit) begin
            tick = 1'b1;
            if (laps_q != LAPS_MAX) laps_d = laps_q + 1'b1;
            if (mode_q) begin
              cnt_clr = 1'b1;  // periodic: restart from 0 on the next edge
            end else begin
              done    = 1'b1;  // one-shot: the counter holds at limit
              state_d = IDLE;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;
  logic       clk = 1'b0;
  logic       reset, start, stop, mode;
  logic [3:0] limit;
  logic [3:0] cnt;
  logic       cnt_en, cnt_clr, busy, tick, done, err;
  logic [7:0] laps;
  int         n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(4), .LAPW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .limit(limit), .cnt_q(cnt), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .busy(busy), .tick(tick), .done(done), .err(err), .laps(laps)
  );

  // The 4-bit counter datapath that the sequencer controls.
  always_ff @(posedge clk) begin
    if (cnt_clr)     cnt <= '0;
    else if (cnt_en) cnt <= cnt + 4'd1;
  end

  // {cnt_en, cnt_clr, busy, tick, done, err}
  wire [5:0] outs = {cnt_en, cnt_clr, busy, tick, done, err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs are driven 1 time unit after the rising edge.
  // Outputs are sampled on the falling edge.
  task automatic adv();
    @(posedge clk); #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; limit = 4'd0;

    // Reset and idle
    adv(); smp();
    chk("rst_outs", outs, 6'b010000);
    chk("rst_laps", laps, 0);
    adv(); smp();
    chk("rst_outs2", outs, 6'b010000);
    adv();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp(); chk("idle_outs", outs, 6'b000000); chk("idle_laps", laps, 0);
      adv();
    end

    // One-shot, limit = 5
    start = 1'b1; mode = 1'b0; limit = 4'd5;
    smp(); chk("os_start", outs, 6'b000000);
    adv(); start = 1'b0; limit = 4'd0;
    smp(); chk("os_clear", outs, 6'b011000);
    adv();
    for (int k = 0; k < 6; k++) begin
      smp();
      chk("os_cnt", cnt, k);
      chk("os_outs", outs, (k < 5) ? 6'b101000 : 6'b001110);
      adv();
    end
    smp();
    chk("os_after_outs", outs, 6'b000000);
    chk("os_after_cnt", cnt, 5);
    chk("os_after_laps", laps, 1);
    adv();

    // Periodic, limit = 3, for 20 RUN cycles
    start = 1'b1; mode = 1'b1; limit = 4'd3;
    adv(); start = 1'b0;
    smp(); chk("per_clear", outs, 6'b011000); chk("per_laps0", laps, 0);
    adv();
    for (int i = 0; i < 20; i++) begin
      smp();
      chk("per_cnt", cnt, i % 4);
      chk("per_outs", outs, (i % 4 == 3) ? 6'b011100 : 6'b101000);
      chk("per_laps", laps, i / 4);
      adv();
    end
    stop = 1'b1;
    smp(); chk("per_stop", outs, 6'b011010);
    adv(); stop = 1'b0;
    smp(); chk("per_idle", outs, 6'b000000); chk("per_laps_kept", laps, 5);
    adv();

    // Stop coinciding with a hit (periodic, limit = 2)
    start = 1'b1; mode = 1'b1; limit = 4'd2;
    adv(); start = 1'b0;
    adv();                               // CLEAR
    for (int i = 0; i < 5; i++) adv();   // 0,1,2(hit),0,1
    stop = 1'b1;
    smp();
    chk("sh_cnt", cnt, 2);
    chk("sh_outs", outs, 6'b011010);
    chk("sh_laps", laps, 1);
    adv(); stop = 1'b0;
    smp(); chk("sh_idle", outs, 6'b000000); chk("sh_laps_kept", laps, 1);
    chk("sh_cnt_clr", cnt, 0);
    adv();

    // limit = 0 is rejected; start+stop together is ignored; stop in IDLE does nothing
    start = 1'b1; limit = 4'd0; mode = 1'b0;
    smp(); chk("err_pulse", outs, 6'b000001);
    adv(); start = 1'b0;
    smp(); chk("err_idle", outs, 6'b000000);
    adv();
    start = 1'b1; stop = 1'b1; limit = 4'd4;
    smp(); chk("ss_ignored", outs, 6'b000000);
    adv(); start = 1'b0;
    smp(); chk("ss_idle", outs, 6'b000000); chk("ss_laps", laps, 1);
    adv(); stop = 1'b0;

    // Start during RUN is ignored (one-shot limit = 3, re-start tries limit = 1 periodic)
    start = 1'b1; mode = 1'b0; limit = 4'd3;
    adv(); start = 1'b0;
    adv();                               // CLEAR
    start = 1'b1; mode = 1'b1; limit = 4'd1;
    smp(); chk("rr_cnt0", outs, 6'b101000);
    adv();
    smp(); chk("rr_cnt1", outs, 6'b101000);   // a limit of 1 would hit here
    adv(); start = 1'b0;
    smp(); chk("rr_cnt2", outs, 6'b101000);
    adv();
    smp(); chk("rr_hit", outs, 6'b001110); chk("rr_hitcnt", cnt, 3);
    adv();
    smp(); chk("rr_idle", outs, 6'b000000);
    adv();

    // Reset mid-run (periodic, limit = 9, reset at cnt = 4)
    start = 1'b1; mode = 1'b1; limit = 4'd9;
    adv(); start = 1'b0;
    adv();
    for (int k = 0; k < 4; k++) adv();
    reset = 1'b1;
    smp();
    chk("mr_cnt", cnt, 4);
    chk("mr_ctl", {cnt_en, cnt_clr, tick, done, err}, 5'b01000);
    adv(); reset = 1'b0;
    smp();
    chk("mr_idle", outs, 6'b000000);
    chk("mr_laps", laps, 0);
    chk("mr_cnt0", cnt, 0);
    adv();

    // Maximum limit 15, one-shot: hit at 15 without wrapping
    start = 1'b1; mode = 1'b0; limit = 4'd15;
    adv(); start = 1'b0;
    adv();
    for (int k = 0; k < 15; k++) adv();
    smp(); chk("max_cnt", cnt, 15); chk("max_hit", outs, 6'b001110);
    adv();

    // laps saturates at 255 (periodic, limit = 1, 260 laps)
    start = 1'b1; mode = 1'b1; limit = 4'd1;
    adv(); start = 1'b0;
    adv();
    for (int i = 0; i < 520; i++) adv();
    smp(); chk("sat_laps", laps, 255);
    stop = 1'b1;
    adv(); stop = 1'b0;
    smp(); chk("sat_idle", outs, 6'b000000); chk("sat_kept", laps, 255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
